// File: rtl/object_locator_pkg.sv
// Shared types, widths and the colour-match helper for the object locator.
package object_locator_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DIV_X,
        DIV_Y,
        PUBLISH
    } state_t;

    localparam int CNT_W      = 17;
    localparam int SUM_W      = 25;
    localparam int DIV_CYCLES = 25;

    // The green test g6[5:1] <= g_max is done on the full 6-bit field
    // as g6 <= {g_max, 1}, which is equivalent and uses every pixel bit.
    function automatic logic rgb565_match(
        input logic [15:0] pixel,
        input logic [4:0]  r_min,
        input logic [4:0]  g_max,
        input logic [4:0]  b_max
    );
        return (pixel[15:11] >= r_min) &&
               (pixel[10:5]  <= {g_max, 1'b1}) &&
               (pixel[4:0]   <= b_max);
    endfunction

endpackage

// File: rtl/object_locator_seq_divider.sv
// Restoring divider, one quotient bit per cycle. The first step is taken in
// the cycle start is high, using the dividend/divisor inputs directly, so a
// new division can be launched in the same cycle the previous one reports
// done. done is high for one cycle once the quotient is complete; the
// quotient then holds until the next start.
module seq_divider
    import object_locator_pkg::*;
#(
    parameter int DVD_W   = SUM_W,
    parameter int DVS_W   = CNT_W,
    parameter int N_STEPS = DIV_CYCLES
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);

    localparam int CB = $clog2(N_STEPS + 1);
    localparam logic [CB-1:0] LOAD_CNT = CB'(N_STEPS - 1);
    localparam logic [CB-1:0] LAST_CNT = CB'(1);

    logic [DVS_W-1:0] r_rem;
    logic [DVS_W-1:0] r_dvs;
    logic [DVD_W-1:0] r_quo;
    logic [CB-1:0]    r_cnt;
    logic             r_done;

    logic [DVS_W-1:0] w_src_rem;
    logic [DVD_W-1:0] w_src_quo;
    logic [DVS_W-1:0] w_dvs;
    logic [DVS_W:0]   w_shift;
    logic             w_ge;
    logic [DVS_W-1:0] w_sub;
    logic [DVS_W-1:0] w_rem_nxt;

    assign w_src_rem = start ? '0 : r_rem;
    assign w_src_quo = start ? dividend : r_quo;
    assign w_dvs     = start ? divisor : r_dvs;
    assign w_shift   = {w_src_rem, w_src_quo[DVD_W-1]};
    assign w_ge      = (w_shift >= {1'b0, w_dvs});
    // When w_ge holds the true difference is below the divisor, so the
    // low DVS_W bits of the subtraction are exact.
    assign w_sub     = w_shift[DVS_W-1:0] - w_dvs;
    assign w_rem_nxt = w_ge ? w_sub : w_shift[DVS_W-1:0];

    // One shift-subtract step per cycle while a division is in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rem  <= '0;
            r_dvs  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start || (r_cnt != '0)) begin
                r_rem  <= w_rem_nxt;
                r_quo  <= {w_src_quo[DVD_W-2:0], w_ge};
                r_dvs  <= w_dvs;
                r_cnt  <= start ? LOAD_CNT : (r_cnt - 1'b1);
                r_done <= !start && (r_cnt == LAST_CNT);
            end
        end
    end

    assign done     = r_done;
    assign quotient = r_quo;

endmodule

// File: rtl/object_locator.sv
// Finds the centroid of target-coloured pixels in each frame of the camera
// stream and publishes it some fixed cycles after frame end.
module object_locator
    import object_locator_pkg::*;
#(
    parameter int R_MIN     = 20,
    parameter int G_MAX     = 10,
    parameter int B_MAX     = 10,
    parameter int MIN_COUNT = 16,
    parameter int H_ACTIVE  = 320,
    parameter int V_ACTIVE  = 240
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        pixel_valid,
    input  logic        frame_start,
    input  logic        frame_end,
    input  logic [8:0]  x,
    input  logic [7:0]  y,
    input  logic [15:0] pixel,
    output logic [8:0]  x_pos,
    output logic [7:0]  y_pos,
    output logic        found,
    output logic        pos_valid,
    output logic        busy
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SUM_W-1:0] r_sum_x;
    logic [SUM_W-1:0] r_sum_y;
    logic [8:0]       r_qx;
    logic             r_pub_found;
    logic [8:0]       r_x_pos;
    logic [7:0]       r_y_pos;
    logic             r_found;
    logic             r_pos_valid;
    logic             r_busy;

    logic             w_match;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [SUM_W-1:0] w_sx_nxt;
    logic [SUM_W-1:0] w_sy_nxt;
    logic             w_enough;
    logic             w_frame_live;
    logic             w_start_x;
    logic             w_start_y;
    logic             w_div_start;
    logic [SUM_W-1:0] w_div_dvd;
    logic [CNT_W-1:0] w_div_dvs;
    logic             w_div_done;
    logic [SUM_W-1:0] w_quo;
    logic             w_unused_quo;

    assign w_match = pixel_valid &&
                     (x < 9'(H_ACTIVE)) && (y < 8'(V_ACTIVE)) &&
                     rgb565_match(pixel, 5'(R_MIN), 5'(G_MAX), 5'(B_MAX));

    // frame_start drops whatever was accumulated and seeds with this pixel.
    assign w_cnt_nxt = (frame_start ? '0 : r_cnt) + {{(CNT_W-1){1'b0}}, w_match};
    assign w_sx_nxt  = (frame_start ? '0 : r_sum_x) + (w_match ? SUM_W'(x) : '0);
    assign w_sy_nxt  = (frame_start ? '0 : r_sum_y) + (w_match ? SUM_W'(y) : '0);
    assign w_enough  = (w_cnt_nxt >= CNT_W'(MIN_COUNT));

    assign w_frame_live = (r_state == ACCUM) || ((r_state == IDLE) && frame_start);

    // X division launches in the frame_end cycle from the final sums; Y
    // launches in the cycle X reports done, reusing the same divider.
    assign w_start_x   = w_frame_live && frame_end && w_enough;
    assign w_start_y   = (r_state == DIV_X) && w_div_done;
    assign w_div_start = w_start_x || w_start_y;
    assign w_div_dvd   = w_start_x ? w_sx_nxt : r_sum_y;
    assign w_div_dvs   = w_start_x ? w_cnt_nxt : r_cnt;

    seq_divider #(
        .DVD_W  (SUM_W),
        .DVS_W  (CNT_W),
        .N_STEPS(DIV_CYCLES)
    ) u_div (
        .clock   (clock),
        .resetn  (resetn),
        .start   (w_div_start),
        .dividend(w_div_dvd),
        .divisor (w_div_dvs),
        .done    (w_div_done),
        .quotient(w_quo)
    );

    // Quotients are guaranteed inside the active area, so the high bits
    // never carry information.
    assign w_unused_quo = ^w_quo[SUM_W-1:9];

    // Frame accumulation, divide sequencing and registered result publish.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_sum_x     <= '0;
            r_sum_y     <= '0;
            r_qx        <= '0;
            r_pub_found <= 1'b0;
            r_x_pos     <= '0;
            r_y_pos     <= '0;
            r_found     <= 1'b0;
            r_pos_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_pos_valid <= 1'b0;
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_frame_live) begin
                        r_cnt   <= w_cnt_nxt;
                        r_sum_x <= w_sx_nxt;
                        r_sum_y <= w_sy_nxt;
                        if (frame_end) begin
                            r_busy <= 1'b1;
                            if (w_enough) begin
                                r_state <= DIV_X;
                            end else begin
                                r_pub_found <= 1'b0;
                                r_state     <= PUBLISH;
                            end
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                DIV_X: begin
                    if (w_div_done) begin
                        r_qx    <= w_quo[8:0];
                        r_state <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    if (w_div_done) begin
                        r_pub_found <= 1'b1;
                        r_state     <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    r_pos_valid <= 1'b1;
                    r_found     <= r_pub_found;
                    if (r_pub_found) begin
                        r_x_pos <= r_qx;
                        r_y_pos <= w_quo[7:0];
                    end
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign x_pos     = r_x_pos;
    assign y_pos     = r_y_pos;
    assign found     = r_found;
    assign pos_valid = r_pos_valid;
    assign busy      = r_busy;

endmodule
